// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and alignment check for the load/store unit
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;

  // Size 11 has no encoding, so it is rejected together with the misaligned cases.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00) || size == 2'b11;
  endfunction
endpackage

// File: rtl/lsu_lanes.sv
// lsu_lanes: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lanes
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask;
  logic [31:0] hmask;

  // Select the addressed lane, extend it, and splice store data into the old word.
  always_comb begin
    bsh = {addr, 3'b000};
    hsh = {addr[1], 4'b0000};
    b = 8'(word >> bsh);
    h = 16'(word >> hsh);
    bmask = 32'h0000_00ff << bsh;
    hmask = 32'h0000_ffff << hsh;
    load_data = size == SZ_BYTE ? {{24{sgn & b[7]}}, b}
              : size == SZ_HALF ? {{16{sgn & h[15]}}, h}
              : word;
    merged = size == SZ_BYTE ? (word & ~bmask) | ({24'b0, wdata[7:0]} << bsh)
           : size == SZ_HALF ? (word & ~hmask) | ({16'b0, wdata[15:0]} << hsh)
           : wdata;
  end
endmodule

// File: rtl/lsu.sv
// lsu: one-at-a-time load/store unit turning byte/half/word requests into dmem word accesses
module lsu
  import lsu_pkg::*;
#(
  parameter int n = 32,
  parameter int r = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [n-1:0] req_addr,
  input  logic [n-1:0] req_wdata,
  output logic         resp_valid,
  output logic [n-1:0] resp_rdata,
  output logic         resp_err,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic         mem_write,
  input  logic [n-1:0] mem_rdata
);
  lsu_state_t   state;
  lsu_state_t   nxt;
  logic         wr_q;
  logic [1:0]   size_q;
  logic         sgn_q;
  logic [r+1:0] addr_q;
  logic [n-1:0] wd_q;
  logic [n-1:0] load_data;
  logic [n-1:0] merged;
  logic         acc;
  logic         bad;
  logic         unused_addr;

  assign unused_addr = ^req_addr[n-1:r+2];
  assign req_ready   = state == IDLE;
  assign acc         = req_valid && req_ready;
  assign bad         = misaligned(req_size, req_addr[1:0]);
  assign resp_valid  = state == RESP;
  assign mem_write   = state == WR;
  assign mem_wdata   = state == WR ? wd_q : '0;
  assign mem_addr    = (state == RD || state == WR) ? {{(n-r){1'b0}}, addr_q[r+1:2]} : '0;

  lsu_lanes u_lanes (
    .word     (mem_rdata),
    .addr     (addr_q[1:0]),
    .size     (size_q),
    .sgn      (sgn_q),
    .wdata    (wd_q),
    .load_data(load_data),
    .merged   (merged)
  );

  // State register; async reset drops mem_write immediately since it decodes WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end

  // Word stores skip the read; everything else that is legal reads first.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (acc) nxt = bad ? RESP : (req_write && req_size == SZ_WORD) ? WR : RD;
      RD:   nxt = wr_q ? WR : RESP;
      WR:   nxt = RESP;
      RESP: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Latch the request; in RD either capture load data or fold the old word into the store data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b0;
      size_q <= SZ_BYTE;
      sgn_q <= 1'b0;
      addr_q <= '0;
      wd_q <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else if (acc) begin
      wr_q <= req_write;
      size_q <= req_size;
      sgn_q <= req_signed;
      addr_q <= req_addr[r+1:0];
      wd_q <= req_wdata;
      resp_rdata <= '0;
      resp_err <= bad;
    end else if (state == RD) begin
      if (wr_q) wd_q <= merged;
      else resp_rdata <= load_data;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard bench for lsu against a small word-addressed memory model
module tb_lsu;
  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_write = 0;
  logic [1:0]  req_size = 0;
  logic        req_signed = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [31:0] mem [128];

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int resp_cnt = 0;

  lsu #(.n(32), .r(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // dmem: combinational read, write on the rising edge
  assign mem_rdata = mem[mem_addr[6:0]];
  always @(posedge clk) if (mem_write) mem[mem_addr[6:0]] <= mem_wdata;

  // Scoreboard: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && mem_write) wr_cnt++;
    if (rst_n && resp_valid) begin
      resp_cnt++;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected: rdata=%h err=%b with nothing outstanding", resp_rdata, resp_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (resp_rdata !== e.rd || resp_err !== e.err) begin
          failures++;
          $display("FAIL resp_data: got rdata=%h err=%b want rdata=%h err=%b", resp_rdata, resp_err, e.rd, e.err);
        end
      end
    end
  end

  task automatic send(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_e, output int lat);
    int g;
    exp_t e;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk);
    e.rd = exp_rd; e.err = exp_e;
    q.push_back(e);
    @(negedge clk);
    req_valid = 0;
    req_wdata = 32'hBAD0BAD0; req_addr = 32'h0000_0001;
    lat = 1;
    while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1 || resp_valid !== 0 || resp_rdata !== 0 || resp_err !== 0 ||
        mem_addr !== 0 || mem_wdata !== 0 || mem_write !== 0) begin
      failures++;
      $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b maddr=%h mwdata=%h mwrite=%b want 1 0 0 0 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write);
    end
    rst_n = 1;
  endtask

  task automatic test_word();
    int lat;
    int w0;
    w0 = wr_cnt;
    send(1, 2'b10, 0, 32'h54, 32'hDEADBEEF, 32'h0, 0, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL word_store_lat: got %0d want 2", lat); end
    @(negedge clk);
    checks++;
    if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL word_store_pulses: got %0d want 1", wr_cnt - w0); end
    checks++;
    if (mem[7'h15] !== 32'hDEADBEEF) begin failures++; $display("FAIL word_store_mem: got %h want deadbeef", mem[7'h15]); end
    send(0, 2'b10, 0, 32'h54, 32'h0, 32'hDEADBEEF, 0, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL word_load_lat: got %0d want 2", lat); end
  endtask

  task automatic test_reset_mid_rmw();
    int lat;
    @(negedge clk);
    req_write = 1; req_size = 2'b00; req_signed = 0; req_addr = 32'h54; req_wdata = 32'h000000AA; req_valid = 1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    @(posedge clk);
    #2;
    checks++;
    if (mem_write !== 1) begin failures++; $display("FAIL rmw_in_wr: mem_write got %b want 1", mem_write); end
    rst_n = 0;
    #1;
    checks++;
    if (mem_write !== 0) begin failures++; $display("FAIL rst_async_write: got %b want 0", mem_write); end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (mem_write !== 0 || resp_valid !== 0) begin
        failures++;
        $display("FAIL rst_hold: mem_write=%b resp_valid=%b want 0 0", mem_write, resp_valid);
      end
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || resp_valid !== 0) begin
      failures++;
      $display("FAIL rst_release: ready=%b valid=%b want 1 0", req_ready, resp_valid);
    end
    checks++;
    if (mem[7'h15] !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_mem_kept: got %h want deadbeef", mem[7'h15]); end
    send(0, 2'b10, 0, 32'h54, 32'h0, 32'hDEADBEEF, 0, lat);
  endtask

  task automatic test_byte_store();
    int lat;
    int w0;
    w0 = wr_cnt;
    send(1, 2'b00, 0, 32'h55, 32'h12345678, 32'h0, 0, lat);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL byte_store_lat: got %0d want 3", lat); end
    @(negedge clk);
    checks++;
    if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL byte_store_pulses: got %0d want 1", wr_cnt - w0); end
    checks++;
    if (mem[7'h15] !== 32'hDEAD78EF) begin failures++; $display("FAIL byte_store_mem: got %h want dead78ef", mem[7'h15]); end
  endtask

  task automatic test_loads();
    int lat;
    send(0, 2'b00, 1, 32'h57, 32'h0, 32'hFFFFFFDE, 0, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL lb_lat: got %0d want 2", lat); end
    send(0, 2'b00, 0, 32'h57, 32'h0, 32'h000000DE, 0, lat);
    send(0, 2'b01, 1, 32'h56, 32'h0, 32'hFFFFDEAD, 0, lat);
    send(0, 2'b01, 0, 32'h54, 32'h0, 32'h000078EF, 0, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL lhu_lat: got %0d want 2", lat); end
  endtask

  task automatic test_errors();
    int lat;
    int w0;
    w0 = wr_cnt;
    send(1, 2'b10, 0, 32'h57, 32'h55555555, 32'h0, 1, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL err_sw_lat: got %0d want 1", lat); end
    send(0, 2'b01, 1, 32'h55, 32'h0, 32'h0, 1, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL err_lh_lat: got %0d want 1", lat); end
    send(0, 2'b11, 0, 32'h54, 32'h0, 32'h0, 1, lat);
    send(1, 2'b11, 0, 32'h54, 32'h66666666, 32'h0, 1, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL err_sz11_lat: got %0d want 1", lat); end
    @(negedge clk);
    checks++;
    if (wr_cnt !== w0) begin failures++; $display("FAIL err_no_write: got %0d pulses want 0", wr_cnt - w0); end
    checks++;
    if (mem[7'h15] !== 32'hDEAD78EF) begin failures++; $display("FAIL err_mem_kept: got %h want dead78ef", mem[7'h15]); end
  endtask

  task automatic test_back_to_back();
    logic        w [3]  = '{1, 0, 0};
    logic [1:0]  s [3]  = '{2'b10, 2'b10, 2'b00};
    logic [31:0] a [3]  = '{32'h60, 32'h60, 32'h61};
    logic [31:0] d [3]  = '{32'h11223344, 32'h0, 32'h0};
    logic [31:0] x [3]  = '{32'h0, 32'h11223344, 32'h00000033};
    int n_acc = 0;
    int cyc = 0;
    int r0;
    logic rdy;
    exp_t e;
    r0 = resp_cnt;
    @(negedge clk);
    req_write = w[0]; req_size = s[0]; req_signed = 0; req_addr = a[0]; req_wdata = d[0]; req_valid = 1;
    while (n_acc < 3 && cyc < 60) begin
      rdy = req_ready;
      @(posedge clk);
      cyc++;
      if (rdy) begin
        e.rd = x[n_acc]; e.err = 0;
        q.push_back(e);
        n_acc++;
      end
      @(negedge clk);
      if (rdy) begin
        checks++;
        if (req_ready !== 0) begin failures++; $display("FAIL b2b_busy: req_ready got %b want 0 after accept", req_ready); end
        if (n_acc < 3) begin
          req_write = w[n_acc]; req_size = s[n_acc]; req_addr = a[n_acc]; req_wdata = d[n_acc];
        end else req_valid = 0;
      end
    end
    req_valid = 0;
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    checks++;
    if (n_acc !== 3 || resp_cnt - r0 !== 3 || q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_count: accepts=%0d resps=%0d pending=%0d want 3 3 0", n_acc, resp_cnt - r0, q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
    test_reset();
    test_word();
    test_reset_mid_rmw();
    test_byte_store();
    test_loads();
    test_errors();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
